// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle IF/DEC/EXE/MEM/WB control unit for the MIPS core
module multicycle_ctrl_fsm #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       ir_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord,
    output logic       rf_we,
    output logic       rf_dst,
    output logic       rf_src,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_DEC  = 3'd2,
        S_EXE  = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Terminal count of the memory wait counter; IF and MEM last MEM_LAT cycles.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [5:0] op_q;
    logic       cnt_last;
    logic       dec_legal;

    assign cnt_last = (cnt_q == LAST_CNT);

    // Opcodes that continue into EXE; j retires in DEC, anything else is illegal.
    assign dec_legal = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                       (opcode == OP_ADDI) || (opcode == OP_BEQ);

    // State register, memory wait counter (cleared on every state change) and opcode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= 4'd0;
            end else if (state_q == S_IF || state_q == S_MEM) begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (state_q == S_DEC) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state sequencing through the instruction phases.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                if (cnt_last) state_d = S_DEC;
            end
            S_DEC: begin
                if (dec_legal) state_d = S_EXE;
                else           state_d = S_IF;
            end
            S_EXE: begin
                if (op_q == OP_LW || op_q == OP_SW)       state_d = S_MEM;
                else if (op_q == OP_R || op_q == OP_ADDI) state_d = S_WB;
                else                                      state_d = S_IF;
            end
            S_MEM: begin
                if (cnt_last) state_d = (op_q == OP_LW) ? S_WB : S_IF;
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode; DEC looks at the freshly loaded IR, beq EXE passes zero to pc_we.
    always_comb begin
        pc_we      = 1'b0;
        pc_sel     = 2'b00;
        ir_we      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        rf_we      = 1'b0;
        rf_dst     = 1'b0;
        rf_src     = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_IF: begin
                mem_re = 1'b1;
                if (cnt_last) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            S_DEC: begin
                if (opcode == OP_J) begin
                    pc_we      = 1'b1;
                    pc_sel     = 2'b10;
                    instr_done = 1'b1;
                end else if (!dec_legal) begin
                    illegal_op = 1'b1;
                end
            end
            S_EXE: begin
                if (op_q == OP_R) begin
                    alu_op = 2'b10;
                end else if (op_q == OP_LW || op_q == OP_SW || op_q == OP_ADDI) begin
                    alu_src_b = 1'b1;
                end else if (op_q == OP_BEQ) begin
                    alu_op     = 2'b01;
                    pc_sel     = 2'b01;
                    pc_we      = zero;
                    instr_done = 1'b1;
                end
            end
            S_MEM: begin
                iord = 1'b1;
                if (op_q == OP_LW) begin
                    mem_re = 1'b1;
                end else if (cnt_last) begin
                    mem_we     = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                rf_dst     = (op_q == OP_R);
                rf_src     = (op_q == OP_LW);
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // A reset cycle must never leak a strobe, even mid-instruction.
        if (rst) begin
            pc_we      = 1'b0;
            pc_sel     = 2'b00;
            ir_we      = 1'b0;
            mem_re     = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            rf_we      = 1'b0;
            rf_dst     = 1'b0;
            rf_src     = 1'b0;
            alu_src_b  = 1'b0;
            alu_op     = 2'b00;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - model-checked bench for multicycle_ctrl_fsm at MEM_LAT 1 and 3
module tb_multicycle_ctrl_fsm;

    // Output vector layout: {state[2:0], pc_we, pc_sel[1:0], ir_we, mem_re, mem_we, iord,
    //                        rf_we, rf_dst, rf_src, alu_src_b, alu_op[1:0], instr_done, illegal_op}
    localparam logic [17:0] B_PCWE   = 18'h1 << 14;
    localparam logic [17:0] B_SEL_BR = 18'h1 << 12;
    localparam logic [17:0] B_SEL_J  = 18'h2 << 12;
    localparam logic [17:0] B_IRWE   = 18'h1 << 11;
    localparam logic [17:0] B_MEMRE  = 18'h1 << 10;
    localparam logic [17:0] B_MEMWE  = 18'h1 << 9;
    localparam logic [17:0] B_IORD   = 18'h1 << 8;
    localparam logic [17:0] B_RFWE   = 18'h1 << 7;
    localparam logic [17:0] B_RFDST  = 18'h1 << 6;
    localparam logic [17:0] B_RFSRC  = 18'h1 << 5;
    localparam logic [17:0] B_SRCB   = 18'h1 << 4;
    localparam logic [17:0] B_SUB    = 18'h1 << 2;
    localparam logic [17:0] B_FN     = 18'h2 << 2;
    localparam logic [17:0] B_DONE   = 18'h1 << 1;
    localparam logic [17:0] B_ILL    = 18'h1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam int DEPTH = 256;

    logic            clk = 1'b0;
    logic            rst_s [2];
    logic [5:0]      op_s  [2];
    logic            z_s   [2];
    logic [1:0][17:0] ov;

    logic [17:0] exp_v [2][DEPTH];
    logic        st_r  [2][DEPTH];
    logic [5:0]  st_op [2][DEPTH];
    logic        st_z  [2][DEPTH];
    int          len   [2];

    int tests = 0;
    int failures = 0;
    int cur_k = 0;
    bit active = 1'b0;
    int done_cnt [2];
    int ill_cnt  [2];
    int mw_cnt   [2];
    int rfwe_cnt [2];

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst_s[0]), .opcode(op_s[0]), .zero(z_s[0]),
        .pc_we(ov[0][14]), .pc_sel(ov[0][13:12]), .ir_we(ov[0][11]), .mem_re(ov[0][10]),
        .mem_we(ov[0][9]), .iord(ov[0][8]), .rf_we(ov[0][7]), .rf_dst(ov[0][6]),
        .rf_src(ov[0][5]), .alu_src_b(ov[0][4]), .alu_op(ov[0][3:2]),
        .instr_done(ov[0][1]), .illegal_op(ov[0][0]), .state(ov[0][17:15])
    );

    multicycle_ctrl_fsm #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst_s[1]), .opcode(op_s[1]), .zero(z_s[1]),
        .pc_we(ov[1][14]), .pc_sel(ov[1][13:12]), .ir_we(ov[1][11]), .mem_re(ov[1][10]),
        .mem_we(ov[1][9]), .iord(ov[1][8]), .rf_we(ov[1][7]), .rf_dst(ov[1][6]),
        .rf_src(ov[1][5]), .alu_src_b(ov[1][4]), .alu_op(ov[1][3:2]),
        .instr_done(ov[1][1]), .illegal_op(ov[1][0]), .state(ov[1][17:15])
    );

    function automatic logic [17:0] st(input int s);
        return {3'(s), 15'd0};
    endfunction

    task automatic push(input int d, input logic r, input logic [5:0] op, input logic z,
                        input logic [17:0] v);
        st_r[d][len[d]]  = r;
        st_op[d][len[d]] = op;
        st_z[d][len[d]]  = z;
        exp_v[d][len[d]] = v;
        len[d]++;
    endtask

    // Expands one instruction into its expected cycle list from the phase rules.
    // cut >= 0: rst is asserted on cycle 'cut' of the instruction instead.
    task automatic add_instr(input int d, input int lat, input logic [5:0] op,
                             input logic z, input int cut, output int ncyc);
        logic [17:0] t [32];
        int n = 0;
        bit fin = 1'b0;
        bit is_lw = (op == OP_LW);
        bit is_sw = (op == OP_SW);
        for (int i = 0; i < lat; i++) begin
            t[n] = st(1) | B_MEMRE | ((i == lat - 1) ? (B_IRWE | B_PCWE) : 18'd0);
            n++;
        end
        if (op == OP_J) begin
            t[n] = st(2) | B_PCWE | B_SEL_J | B_DONE; n++; fin = 1'b1;
        end else if (!(op == OP_R || is_lw || is_sw || op == OP_ADDI || op == OP_BEQ)) begin
            t[n] = st(2) | B_ILL; n++; fin = 1'b1;
        end else begin
            t[n] = st(2); n++;
        end
        if (!fin) begin
            if (op == OP_BEQ) begin
                t[n] = st(3) | B_SUB | B_SEL_BR | (z ? B_PCWE : 18'd0) | B_DONE; n++; fin = 1'b1;
            end else begin
                t[n] = st(3) | ((op == OP_R) ? B_FN : B_SRCB); n++;
            end
        end
        if (!fin && (is_lw || is_sw)) begin
            for (int i = 0; i < lat; i++) begin
                if (is_lw) t[n] = st(4) | B_IORD | B_MEMRE;
                else       t[n] = st(4) | B_IORD | ((i == lat - 1) ? (B_MEMWE | B_DONE) : 18'd0);
                n++;
            end
            if (is_sw) fin = 1'b1;
        end
        if (!fin) begin
            t[n] = st(5) | B_RFWE | B_DONE | ((op == OP_R) ? B_RFDST : 18'd0) |
                   (is_lw ? B_RFSRC : 18'd0);
            n++;
        end
        ncyc = n;
        if (cut >= 0) begin
            for (int i = 0; i < cut; i++) push(d, 1'b0, op, z, t[i]);
            push(d, 1'b1, op, z, 18'd0);
            push(d, 1'b0, op, z, st(0));
        end else begin
            for (int i = 0; i < n; i++) push(d, 1'b0, op, z, t[i]);
        end
    endtask

    task automatic pin(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic build(input int d, input int lat);
        int n;
        len[d] = 0;
        push(d, 1'b1, OP_R, 1'b0, 18'd0);
        push(d, 1'b1, OP_R, 1'b0, 18'd0);
        push(d, 1'b0, OP_R, 1'b0, st(0));
        add_instr(d, lat, OP_R, 1'b0, -1, n);
        pin($sformatf("len_r_L%0d", lat), n, 3 + lat);
        add_instr(d, lat, OP_LW, 1'b0, -1, n);
        pin($sformatf("len_lw_L%0d", lat), n, 3 + 2 * lat);
        add_instr(d, lat, OP_SW, 1'b0, -1, n);
        pin($sformatf("len_sw_L%0d", lat), n, 2 + 2 * lat);
        add_instr(d, lat, OP_ADDI, 1'b0, -1, n);
        add_instr(d, lat, OP_BEQ, 1'b1, -1, n);
        pin($sformatf("len_beq_L%0d", lat), n, 2 + lat);
        add_instr(d, lat, OP_BEQ, 1'b0, -1, n);
        add_instr(d, lat, OP_J, 1'b0, -1, n);
        pin($sformatf("len_j_L%0d", lat), n, 1 + lat);
        add_instr(d, lat, OP_BAD, 1'b0, -1, n);
        add_instr(d, lat, OP_SW, 1'b0, 2 * lat + 1, n);
        add_instr(d, lat, OP_R, 1'b0, -1, n);
    endtask

    // Single compare process: every cycle, both DUTs against their expected vectors.
    always @(negedge clk) begin
        if (active) begin
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (ov[d] !== exp_v[d][cur_k]) begin
                    failures++;
                    $display("FAIL cycle dut=%0d k=%0d got=%b want=%b", d, cur_k, ov[d],
                             exp_v[d][cur_k]);
                end
                if (ov[d][1] === 1'b1) done_cnt[d]++;
                if (ov[d][0] === 1'b1) ill_cnt[d]++;
                if (ov[d][9] === 1'b1) mw_cnt[d]++;
                if (ov[d][7] === 1'b1) rfwe_cnt[d]++;
            end
        end
    end

    initial begin
        int maxlen;
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; op_s[d] = 6'd0; z_s[d] = 1'b0;
            done_cnt[d] = 0; ill_cnt[d] = 0; mw_cnt[d] = 0; rfwe_cnt[d] = 0;
        end
        build(0, 1);
        build(1, 3);
        pin("lw_L3_is_9", 3 + 2 * 3, 9);
        maxlen = (len[0] > len[1]) ? len[0] : len[1];
        for (int d = 0; d < 2; d++) begin
            while (len[d] < maxlen + 2) push(d, 1'b1, 6'd0, 1'b0, 18'd0);
        end
        for (int k = 0; k < maxlen + 2; k++) begin
            if (k == 0) #1;
            else begin
                @(posedge clk);
                #1;
            end
            for (int d = 0; d < 2; d++) begin
                rst_s[d] = st_r[d][k];
                op_s[d]  = st_op[d][k];
                z_s[d]   = st_z[d][k];
            end
            cur_k  = k;
            active = 1'b1;
        end
        @(posedge clk);
        active = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            pin($sformatf("done_pulses_dut%0d", d), done_cnt[d], 8);
            pin($sformatf("illegal_pulses_dut%0d", d), ill_cnt[d], 1);
            pin($sformatf("mem_we_pulses_dut%0d", d), mw_cnt[d], 1);
            pin($sformatf("rf_we_pulses_dut%0d", d), rfwe_cnt[d], 4);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
